// File: rtl/seq_magnitude_comparator_if.sv
// Start/done handshake and operand/result bundle for the
// multi-cycle magnitude comparator.
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             done;
  logic             ALB;
  logic             AEB;
  logic             AGB;
  logic [WIDTH-1:0] Out;

  modport master (
    output start,
    output is_signed,
    output A,
    output B,
    input  ready,
    input  done,
    input  ALB,
    input  AEB,
    input  AGB,
    input  Out
  );

  modport slave (
    input  start,
    input  is_signed,
    input  A,
    input  B,
    output ready,
    output done,
    output ALB,
    output AEB,
    output AGB,
    output Out
  );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans one DIGIT-bit group
// per cycle, MSB group first, stopping at the first difference.
module seq_magnitude_comparator #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input logic                        clk,
  input logic                        rst,
  seq_magnitude_comparator_if.slave  bus
);
  localparam int NG = WIDTH / DIGIT;
  localparam int IW = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic [DIGIT-1:0] ga;
  logic [DIGIT-1:0] gb;
  logic             alb;
  logic             aeb;
  logic             agb;
  logic             ready;
  logic             done;
  logic             accept;
  logic             set_lt;
  logic             set_eq;
  logic             set_gt;
  logic             step;
  logic             last;
  logic [WIDTH-1:0] flip;

  assign ga   = a_q[idx*DIGIT +: DIGIT];
  assign gb   = b_q[idx*DIGIT +: DIGIT];
  assign last = (idx == '0);

  // Flipping both sign bits maps two's-complement order onto unsigned order
  assign flip = bus.is_signed ? MSB : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    ready   = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    set_lt  = 1'b0;
    set_eq  = 1'b0;
    set_gt  = 1'b0;
    step    = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.start) begin
          accept  = 1'b1;
          state_n = SCAN;
        end
      end
      SCAN: begin
        unique case (1'b1)
          (ga > gb): begin
            set_gt  = 1'b1;
            state_n = DONE;
          end
          (ga < gb): begin
            set_lt  = 1'b1;
            state_n = DONE;
          end
          (ga == gb && last): begin
            set_eq  = 1'b1;
            state_n = DONE;
          end
          default: begin
            step = 1'b1;
          end
        endcase
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      idx <= '0;
      alb <= 1'b0;
      aeb <= 1'b0;
      agb <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= bus.A ^ flip;
        b_q <= bus.B ^ flip;
        idx <= IW'(NG - 1);
        alb <= 1'b0;
        aeb <= 1'b0;
        agb <= 1'b0;
      end
      if (step) begin
        idx <= idx - IW'(1);
      end
      if (set_lt) begin
        alb <= 1'b1;
      end
      if (set_eq) begin
        aeb <= 1'b1;
      end
      if (set_gt) begin
        agb <= 1'b1;
      end
    end
  end

  assign bus.ready = ready;
  assign bus.done  = done;
  assign bus.ALB   = alb;
  assign bus.AEB   = aeb;
  assign bus.AGB   = agb;
  assign bus.Out   = {{(WIDTH-1){1'b0}}, alb};
endmodule
